mvm_param: RTL and testbench
============================

MVM_PARAM -- requirements
Module: mvm_param

Interface
REQ-001 SHALL have parameter N, default 12, matrix dimension (N x N matrix, N-element vectors), N >= 2.
REQ-002 SHALL have parameter P, default 1, number of parallel MAC lanes; P SHALL divide N.
REQ-003 SHALL have parameter IW, default 8, signed input element width.
REQ-004 SHALL have parameter OW, default 2*IW, signed output element width.
REQ-005 SHALL have parameter PIPE, default 0, 1 inserts a register stage between multiplier and adder.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port loadMatrix, input, 1, one-cycle command to begin a matrix load.
REQ-009 SHALL have port loadVector, input, 1, one-cycle command to begin a vector load.
REQ-010 SHALL have port start, input, 1, one-cycle command to begin y = A*x.
REQ-011 SHALL have port data_in, input, IW, signed load data.
REQ-012 SHALL have port done, output, 1, one-cycle pulse marking results ready.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port data_out, output, OW, signed result element.

Function
REQ-015 SHALL implement states IDLE, LOAD_M, LOAD_V, COMPUTE, DONE, OUT.
REQ-016 In IDLE, command priority SHALL be loadMatrix > loadVector > start; lower-priority commands asserted in the same cycle are dropped.
REQ-017 Commands sampled while busy=1 SHALL be ignored.
REQ-018 LOAD_M SHALL capture data_in on the N*N cycles after the command cycle, in row-major order (a[0][0], a[0][1], ...), then return to IDLE.
REQ-019 LOAD_V SHALL capture data_in on the N cycles after the command cycle, x[0] first, then return to IDLE.
REQ-020 Stored matrix and vector SHALL persist across any number of starts until reloaded or reset.
REQ-021 COMPUTE SHALL process P rows per group, one column per cycle, giving N*N/P compute cycles.
REQ-022 Accumulators SHALL be signed, OW+clog2(N) bits wide, with no internal overflow.
REQ-023 done SHALL be high for exactly one cycle, N*N/P + 2 + PIPE cycles after the cycle in which start is sampled.
REQ-024 OUT SHALL present y[j] on data_out during the (j+1)-th cycle after the done cycle, for j = 0..N-1, then return to IDLE.
REQ-025 data_out SHALL be 0 in every state except OUT.
REQ-026 A start with no prior load SHALL use the all-zero reset contents and yield y = 0.

Reset
REQ-027 When reset_n=0, the block SHALL enter IDLE immediately, regardless of state, including mid-load, mid-compute and mid-output.
REQ-028 Reset SHALL force done=0, busy=0 and data_out=0, and SHALL clear the matrix, vector and accumulators to 0.
REQ-029 Commands SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-030 With macro MVM_SAT_EN defined, each result SHALL saturate to the range [-2^(OW-1), 2^(OW-1)-1].
REQ-031 Without MVM_SAT_EN, each result SHALL be the low OW bits of the accumulator (two's-complement wrap).

Verification
REQ-032 Identity check: N=12, P=1; load A=identity, x=0..11, start -> done 146 cycles after start; data_out 0..11 on the 12 following cycles.
REQ-033 Parallel lanes: N=12, P=4, PIPE=1; A all 3, x all -2; start -> done after 39 cycles; every y = -72.
REQ-034 Overflow: IW=8, OW=16; A all -128, x all -128, N=12; start -> y = 32767 with MVM_SAT_EN; without it, y = low 16 bits of 196608, which is 0.
REQ-035 Priority and busy: loadMatrix and start asserted in the same cycle -> matrix load only; start pulsed during the load -> ignored, no done.
REQ-036 Reset mid-compute: drop reset_n for 1 cycle during COMPUTE -> no done, busy=0, data_out=0; a following start with no reload -> all y = 0.
REQ-037 Repeated start: two starts with no reload in between -> identical y sequences.

Source files
------------

// File: rtl/mvm_param.sv
// mvm_param: N x N signed matrix-vector multiplier, y = A*x.
// The matrix and the vector are loaded serially, one element per cycle.
// The compute phase runs P MAC lanes in parallel; each group covers P rows, one column per cycle.
// Results are streamed out one element per cycle after a one-cycle done pulse.
// Optional macro MVM_SAT_EN: saturate results to OW bits instead of wrapping.

// One MAC lane multiplier with an optional product register (PIPE=1).
module mvm_lane #(
   parameter int IW   = 8,
   parameter int XAW  = 4,
   parameter int PIPE = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic signed [IW-1:0]   a,
   input  logic signed [IW-1:0]   b,
   input  logic [XAW-1:0]         row_in,
   input  logic                   vld_in,
   output logic signed [2*IW-1:0] prod,
   output logic [XAW-1:0]         row_out,
   output logic                   vld_out
);
   logic signed [2*IW-1:0] mul;
   assign mul = a * b;

   generate
      if (PIPE != 0) begin : g_pipe
         // Register the product together with its row tag and valid bit
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               prod    <= '0;
               row_out <= '0;
               vld_out <= 1'b0;
            end else begin
               prod    <= mul;
               row_out <= row_in;
               vld_out <= vld_in;
            end
         end
      end else begin : g_comb
         assign prod    = mul;
         assign row_out = row_in;
         assign vld_out = vld_in;
      end
   endgenerate
endmodule

module mvm_param #(
   parameter int N    = 12,
   parameter int P    = 1,
   parameter int IW   = 8,
   parameter int OW   = 2*IW,
   parameter int PIPE = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 loadMatrix,
   input  logic                 loadVector,
   input  logic                 start,
   input  logic signed [IW-1:0] data_in,
   output logic                 done,
   output logic                 busy,
   output logic signed [OW-1:0] data_out
);
   localparam int AW   = OW + $clog2(N);      // accumulator width, cannot overflow
   localparam int NCYC = N*N/P;               // issue cycles
   localparam int LAST = NCYC + PIPE;         // final COMPUTE count before DONE
   localparam int CW   = $clog2(N*N+2);
   localparam int MAW  = $clog2(N*N);
   localparam int XAW  = $clog2(N);
   localparam int OIW  = $clog2(N+1);

   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DONE, OUT} state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [XAW-1:0]         col;
   logic [XAW-1:0]         row_base;
   logic [MAW-1:0]         mbase;
   logic [OIW-1:0]         oidx;
   logic signed [IW-1:0]   mat [N*N];
   logic signed [IW-1:0]   vec [N];
   logic signed [AW-1:0]   acc [N];
   logic                   iss;

   logic signed [IW-1:0]   la      [P];
   logic signed [2*IW-1:0] lprod   [P];
   logic [XAW-1:0]         lrow_in [P];
   logic [XAW-1:0]         lrow    [P];
   logic [P-1:0]           lvld;

`ifdef MVM_SAT_EN
   localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = ~SMAX;
   function automatic logic signed [OW-1:0] out_f(input logic signed [AW-1:0] v);
      if (v > SMAX)      return SMAX[OW-1:0];
      else if (v < SMIN) return SMIN[OW-1:0];
      else               return v[OW-1:0];
   endfunction
`else
   function automatic logic signed [OW-1:0] out_f(input logic signed [AW-1:0] v);
      return v[OW-1:0];
   endfunction
`endif

   assign iss = (state == COMPUTE) && (cnt < CW'(NCYC));

   generate
      for (genvar l = 0; l < P; l++) begin : g_lane
         assign la[l]      = mat[mbase + MAW'(l*N) + MAW'(col)];
         assign lrow_in[l] = row_base + XAW'(l);
         mvm_lane #(.IW(IW), .XAW(XAW), .PIPE(PIPE)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (la[l]),
            .b       (vec[col]),
            .row_in  (lrow_in[l]),
            .vld_in  (iss),
            .prod    (lprod[l]),
            .row_out (lrow[l]),
            .vld_out (lvld[l])
         );
      end
   endgenerate

   // Control FSM, storage and accumulation, all with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         col      <= '0;
         row_base <= '0;
         mbase    <= '0;
         oidx     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         for (int i = 0; i < N*N; i++) mat[i] <= '0;
         for (int i = 0; i < N; i++) begin
            vec[i] <= '0;
            acc[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Priority: loadMatrix > loadVector > start
               if (loadMatrix) begin
                  state <= LOAD_M;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end else if (loadVector) begin
                  state <= LOAD_V;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end else if (start) begin
                  state    <= COMPUTE;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  col      <= '0;
                  row_base <= '0;
                  mbase    <= '0;
                  for (int i = 0; i < N; i++) acc[i] <= '0;
               end
            end
            LOAD_M: begin
               mat[cnt[MAW-1:0]] <= data_in;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N*N-1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            LOAD_V: begin
               vec[cnt[XAW-1:0]] <= data_in;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N-1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            COMPUTE: begin
               cnt <= cnt + 1'b1;
               if (iss) begin
                  if (col == XAW'(N-1)) begin
                     col      <= '0;
                     row_base <= row_base + XAW'(P);
                     mbase    <= mbase + MAW'(P*N);
                  end else begin
                     col <= col + 1'b1;
                  end
               end
               // Extra count(s) past the last issue drain the lane pipeline
               if (cnt == CW'(LAST)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state    <= OUT;
               data_out <= out_f(acc[0]);
               oidx     <= OIW'(1);
            end
            OUT: begin
               if (oidx == OIW'(N)) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  data_out <= '0;
               end else begin
                  data_out <= out_f(acc[oidx[XAW-1:0]]);
                  oidx     <= oidx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         // Lane results land in distinct rows, so they never collide
         for (int l = 0; l < P; l++)
            if (lvld[l]) acc[lrow[l]] <= acc[lrow[l]] + AW'(lprod[l]);
      end
   end
endmodule

// File: tb/tb_mvm_param.sv
// tb_mvm_param: directed bench for mvm_param.
// Two instances share stimulus: a serial build (P=1, PIPE=0) and a parallel one (P=4, PIPE=1).
module tb_mvm_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n, loadMatrix, loadVector, start;
   logic signed [7:0] data_in;
   logic              done1, busy1, done4, busy4;
   logic signed [15:0] dout1, dout4;

   int checks = 0, errors = 0;
   int t1, t4, nd1, nd4, ndl;
   int y1[12], y4[12], yp[12];

`ifdef MVM_SAT_EN
   localparam int OVF = 32767;
`else
   localparam int OVF = 0;
`endif

   mvm_param #(.N(12), .P(1), .IW(8), .OW(16), .PIPE(0)) u_p1 (
      .clk(clk), .reset_n(reset_n), .loadMatrix(loadMatrix), .loadVector(loadVector),
      .start(start), .data_in(data_in), .done(done1), .busy(busy1), .data_out(dout1));

   mvm_param #(.N(12), .P(4), .IW(8), .OW(16), .PIPE(1)) u_p4 (
      .clk(clk), .reset_n(reset_n), .loadMatrix(loadMatrix), .loadVector(loadVector),
      .start(start), .data_in(data_in), .done(done4), .busy(busy4), .data_out(dout4));

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: identity, mode 1: every element = c. A start is pulsed mid-load.
   task automatic load_mat(input int mode, input int c, input bit with_start);
      @(negedge clk); loadMatrix = 1'b1; start = with_start;
      @(negedge clk); loadMatrix = 1'b0; start = 1'b0;
      for (int i = 0; i < 144; i++) begin
         data_in = (mode == 0) ? ((i/12 == i%12) ? 8'sd1 : 8'sd0) : 8'(c);
         start   = (i == 50);
         if (done1 || done4) ndl++;
         if (i == 10) begin
            chk("busy_load_p1", busy1, 1);
            chk("busy_load_p4", busy4, 1);
         end
         @(negedge clk);
      end
      start = 1'b0; data_in = '0;
   endtask

   // mode 0: x[i] = i, mode 1: every element = c
   task automatic load_vec(input int mode, input int c);
      @(negedge clk); loadVector = 1'b1;
      @(negedge clk); loadVector = 1'b0;
      for (int i = 0; i < 12; i++) begin
         data_in = (mode == 0) ? 8'(i) : 8'(c);
         @(negedge clk);
      end
      data_in = '0;
   endtask

   // Pulse start, record done timing (cycle 1 = cycle after start) and outputs
   task automatic run_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      t1 = -1; t4 = -1; nd1 = 0; nd4 = 0;
      for (int j = 0; j < 12; j++) begin y1[j] = 12345; y4[j] = 12345; end
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (done1) begin nd1++; if (t1 < 0) t1 = cyc; end
         if (done4) begin nd4++; if (t4 < 0) t4 = cyc; end
         if (t1 > 0 && cyc > t1 && cyc <= t1 + 12) y1[cyc-t1-1] = int'(dout1);
         if (t4 > 0 && cyc > t4 && cyc <= t4 + 12) y4[cyc-t4-1] = int'(dout4);
         if (cyc == 5) begin
            chk("dout_zero_compute_p1", dout1, 0);
            chk("busy_compute_p1", busy1, 1);
         end
         @(negedge clk);
      end
      chk("done_time_p1", t1, 146);
      chk("done_time_p4", t4, 39);
      chk("done_pulses_p1", nd1, 1);
      chk("done_pulses_p4", nd4, 1);
      chk("busy_end_p1", busy1, 0);
      chk("busy_end_p4", busy4, 0);
      chk("dout_idle_p1", dout1, 0);
      chk("dout_idle_p4", dout4, 0);
   endtask

   task automatic check_all(input string tag, input int exp);
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("%s_p1[%0d]", tag, j), y1[j], exp);
         chk($sformatf("%s_p4[%0d]", tag, j), y4[j], exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0; data_in = '0;
      ndl = 0;
      repeat (3) @(negedge clk);
      chk("rst_done_p1", done1, 0);  chk("rst_done_p4", done4, 0);
      chk("rst_busy_p1", busy1, 0);  chk("rst_busy_p4", busy4, 0);
      chk("rst_dout_p1", dout1, 0);  chk("rst_dout_p4", dout4, 0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Start straight after reset with nothing loaded: y = 0
      run_start();
      check_all("noload_y", 0);

      // Identity matrix; simultaneous start is dropped, mid-load start ignored
      load_mat(0, 0, 1'b1);
      chk("no_done_during_load", ndl, 0);
      load_vec(0, 0);
      run_start();
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("ident_p1[%0d]", j), y1[j], j);
         chk($sformatf("ident_p4[%0d]", j), y4[j], j);
      end

      // All 3 times all -2: 12 * -6 = -72, then again without reload
      load_mat(1, 3, 1'b0);
      load_vec(1, -2);
      run_start();
      check_all("par_y", -72);
      for (int j = 0; j < 12; j++) yp[j] = y1[j];
      run_start();
      check_all("repeat_y", -72);
      for (int j = 0; j < 12; j++) chk($sformatf("repeat_same[%0d]", j), y1[j], yp[j]);

      // -128 * -128 * 12 = 196608 exceeds 16 bits
      load_mat(1, -128, 1'b0);
      load_vec(1, -128);
      run_start();
      check_all("ovf_y", OVF);

      // Reset during compute: no done, outputs quiet, storage cleared
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy_p1", busy1, 0); chk("midrst_busy_p4", busy4, 0);
      chk("midrst_done_p1", done1, 0); chk("midrst_dout_p1", dout1, 0);
      @(negedge clk); reset_n = 1'b1;
      nd1 = 0;
      for (int k = 0; k < 200; k++) begin
         if (done1 || done4) nd1++;
         @(negedge clk);
      end
      chk("midrst_no_done", nd1, 0);
      run_start();
      check_all("postrst_y", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
